// File: rtl/gray_to_rgb_core.sv
// gray_to_rgb_core: frame-framed gray -> RGB555 converter with a small output FIFO.
// A three-state controller (IDLE/PROCESSING/DRAIN) gates pixel intake; each
// accepted gray pixel is replicated into R, G and B and buffered for the sink.
module gray_to_rgb_core #(
   parameter int PIXEL_WIDTH_IN = 8,
   parameter int MAX_PIXEL_BITS = 15,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      start_i,
   input  logic                      finish_i,
   input  logic [PIXEL_WIDTH_IN-1:0] in_px_gray_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [MAX_PIXEL_BITS-1:0] out_px_rgb_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [15:0]               px_count_o
);

   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PROCESSING = 2'd1,
      DRAIN      = 2'd2
   } state_t;

   state_t state, next_state;
   logic   done_q, drain_done;

   // FIFO storage; pointers carry one extra bit so full and empty differ
   logic [MAX_PIXEL_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]               wr_ptr, rd_ptr, occ;
   logic                      fifo_empty, fifo_full;
   logic                      push, pop;
   logic [4:0]                f;
   logic [MAX_PIXEL_BITS-1:0] px_word;
   logic [15:0]               px_cnt;

   // Only the top five gray bits carry into RGB555
   logic unused_gray_lsbs;
   assign unused_gray_lsbs = ^in_px_gray_i[PIXEL_WIDTH_IN-6:0];

   assign occ        = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Full blocks intake even when a pop happens in the same cycle
   assign in_ready_o  = (state == PROCESSING) && !fifo_full;
   assign out_valid_o = !fifo_empty;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   assign f       = in_px_gray_i[PIXEL_WIDTH_IN-1 -: 5];
   assign px_word = MAX_PIXEL_BITS'({f, f, f});

   assign out_px_rgb_o = mem[rd_ptr[AW-1:0]];
   assign busy_o       = (state != IDLE);
   assign done_o       = done_q;
   assign px_count_o   = px_cnt;

   // FIFO write/read pointers and storage; cleared so the head reads 0 after reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= px_word;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Frame pixel counter: cleared at frame start, saturates at all-ones
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         px_cnt <= '0;
      end else if (state == IDLE && start_i) begin
         px_cnt <= '0;
      end else if (push && px_cnt != 16'hFFFF) begin
         px_cnt <= px_cnt + 16'd1;
      end
   end

   // State register plus the registered end-of-frame pulse
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= IDLE;
         done_q <= 1'b0;
      end else begin
         state  <= next_state;
         done_q <= drain_done;
      end
   end

   // Next-state logic; DRAIN exits on the edge where the last entry leaves
   // (no pushes happen in DRAIN, so occupancy 1 plus a pop means empty next)
   always_comb begin
      next_state = state;
      drain_done = 1'b0;
      case (state)
         IDLE:       if (start_i)  next_state = PROCESSING;
         PROCESSING: if (finish_i) next_state = DRAIN;
         DRAIN: begin
            if (fifo_empty || (occ == (AW+1)'(1) && pop)) begin
               next_state = IDLE;
               drain_done = 1'b1;
            end
         end
         default:    next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gray_to_rgb_core.sv
// Self-checking bench for gray_to_rgb_core: scoreboard of expected RGB555 words
// pushed on each accepted pixel and compared as the sink takes output.
module tb_gray_to_rgb_core;

   logic        clk = 1'b0;
   logic        reset_i, start_i, finish_i, in_valid_i, out_ready_i;
   logic [7:0]  in_px_gray_i;
   logic        in_ready_o, out_valid_o, busy_o, done_o;
   logic [14:0] out_px_rgb_o;
   logic [15:0] px_count_o;

   int n_chk = 0;
   int n_bad = 0;
   int n_out = 0;
   logic [14:0] sb[$];
   bit wrap_on = 0;

   always #5 clk = ~clk;

   gray_to_rgb_core #(.PIXEL_WIDTH_IN(8), .MAX_PIXEL_BITS(15), .FIFO_DEPTH(4)) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .finish_i(finish_i),
      .in_px_gray_i(in_px_gray_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .out_px_rgb_o(out_px_rgb_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .busy_o(busy_o), .done_o(done_o), .px_count_o(px_count_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [14:0] conv(input logic [7:0] g);
      return {g[7:3], g[7:3], g[7:3]};
   endfunction

   // Scoreboard monitor, sampled on the falling edge away from the active edge
   always @(negedge clk) begin
      if (!reset_i) begin
         if (out_valid_o && out_ready_i) begin
            n_out++;
            if (sb.size() == 0) chk("sb_unexpected_out", 32'(out_px_rgb_o), 32'hDEAD);
            else chk("px_out", 32'(out_px_rgb_o), 32'(sb.pop_front()));
         end
         if (in_valid_i && in_ready_o) sb.push_back(conv(in_px_gray_i));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_frame();
      start_i = 1'b1; tick(); start_i = 1'b0;
   endtask

   // Offer one pixel for up to max_cyc cycles; acc reports acceptance
   task automatic try_px(input logic [7:0] g, input bit fin, input int max_cyc, output bit acc);
      int n = 0;
      acc = 0;
      in_valid_i = 1'b1; in_px_gray_i = g; finish_i = fin;
      while (!acc && n < max_cyc) begin
         @(negedge clk); acc = in_ready_o;
         tick(); n++;
      end
      in_valid_i = 1'b0; finish_i = 1'b0;
   endtask

   task automatic send_px(input logic [7:0] g, input bit fin);
      bit acc;
      try_px(g, fin, 200, acc);
      chk("px_accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic finish_frame();
      finish_i = 1'b1; tick(); finish_i = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      bit got = 0;
      int n = 0;
      while (!got && n < max_cyc) begin
         @(negedge clk); got = done_o; n++;
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("idle_at_done", 32'(busy_o), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done_o), 32'd0);
      tick();
   endtask

   task automatic do_reset();
      reset_i = 1'b1; tick(); reset_i = 1'b0;
      sb.delete();
   endtask

   initial begin
      bit acc;
      int base;
      logic [14:0] basic_exp [3];
      logic [7:0]  basic_in  [3];
      reset_i = 1'b0; start_i = 1'b0; finish_i = 1'b0; in_valid_i = 1'b0;
      out_ready_i = 1'b0; in_px_gray_i = '0;
      basic_in  = '{8'hFF, 8'h08, 8'h07};
      basic_exp = '{15'h7FFF, 15'h0421, 15'h0000};
      tick();

      // Reset state
      reset_i = 1'b1; tick(); tick(); reset_i = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_in_ready", 32'(in_ready_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_count", 32'(px_count_o), 0);
      chk("rst_px", 32'(out_px_rgb_o), 0);
      tick();

      // Basic conversion and one-cycle latency
      out_ready_i = 1'b1;
      start_frame();
      @(negedge clk);
      chk("basic_busy", 32'(busy_o), 1);
      chk("basic_in_ready", 32'(in_ready_o), 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         send_px(basic_in[i], 1'b0);
         @(negedge clk);
         chk("basic_latency_valid", 32'(out_valid_o), 1);
         chk("basic_px_const", 32'(out_px_rgb_o), 32'(basic_exp[i]));
         tick();
      end
      finish_frame();
      wait_done(20);
      chk("basic_count", 32'(px_count_o), 3);
      chk("basic_sb_empty", 32'(sb.size()), 0);

      // Backpressure: four fit, the fifth stalls, head holds steady
      out_ready_i = 1'b0;
      start_frame();
      for (int i = 0; i < 4; i++) send_px(8'h10 + 8'(i * 40), 1'b0);
      try_px(8'hAA, 1'b0, 5, acc);
      chk("bp_fifth_rejected", 32'(acc), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready_o), 0);
         chk("bp_out_valid", 32'(out_valid_o), 1);
         chk("bp_head_stable", 32'(out_px_rgb_o), 32'(sb[0]));
         tick();
      end
      chk("bp_count", 32'(px_count_o), 4);
      out_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_full_no_pass", 32'(in_ready_o), 0);
      for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
      chk("bp_drained", 32'(sb.size()), 0);
      finish_frame();
      wait_done(20);

      // Finish coincident with an accepted pixel
      start_frame();
      send_px(8'h5C, 1'b1);
      @(negedge clk);
      chk("sim_in_drain", 32'(busy_o), 1);
      chk("sim_count", 32'(px_count_o), 1);
      chk("sim_in_ready", 32'(in_ready_o), 0);
      wait_done(20);
      chk("sim_emitted", 32'(sb.size()), 0);

      // Empty frame
      start_frame();
      finish_frame();
      @(negedge clk);
      chk("empty_drain_busy", 32'(busy_o), 1);
      chk("empty_drain_done", 32'(done_o), 0);
      tick();
      @(negedge clk);
      chk("empty_done", 32'(done_o), 1);
      chk("empty_idle", 32'(busy_o), 0);
      chk("empty_count", 32'(px_count_o), 0);
      tick();
      @(negedge clk);
      chk("empty_done_once", 32'(done_o), 0);
      tick();

      // Reset mid-frame with data buffered
      out_ready_i = 1'b0;
      start_frame();
      for (int i = 0; i < 3; i++) send_px(8'hC0 + 8'(i), 1'b0);
      do_reset();
      @(negedge clk);
      chk("mrst_out_valid", 32'(out_valid_o), 0);
      chk("mrst_busy", 32'(busy_o), 0);
      chk("mrst_count", 32'(px_count_o), 0);
      chk("mrst_px", 32'(out_px_rgb_o), 0);
      for (int i = 0; i < 3; i++) begin
         chk("mrst_no_done", 32'(done_o), 0);
         tick(); @(negedge clk);
      end
      tick();

      // Wrap-around stream with random sink stalls
      base = n_out;
      start_frame();
      wrap_on = 1;
      fork
         begin
            forever begin
               @(posedge clk); #1;
               if (!wrap_on) break;
               out_ready_i = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int i = 0; i < 20; i++) send_px(8'($urandom_range(0, 255)), 1'b0);
      wrap_on = 0;
      @(posedge clk); #2;
      out_ready_i = 1'b1;
      tick();
      finish_frame();
      wait_done(40);
      chk("wrap_count", 32'(px_count_o), 20);
      chk("wrap_out_total", 32'(n_out - base), 20);
      chk("wrap_sb_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
